// File: rtl/cap_comp_pkg.sv
// Shared definitions for the 129-bit capability compressor/decompressor pair.
// Holds field geometry, fill constants and the compressed-capability layout.
package cap_comp_pkg;

    localparam int CAP_W   = 129;
    localparam int TAG_BIT = 128;
    localparam int MANT_HI = 31;
    localparam int MANT_LO = 10;
    localparam int TRUNC_W = 22;
    localparam int FILL_W  = 10;
    localparam int CMP_W   = 119;
    localparam int UPPER_W = 96;

    localparam logic [FILL_W-1:0] FILL_ZERO = 10'h000;
    localparam logic [FILL_W-1:0] FILL_MID  = 10'h200;

    typedef struct packed {
        logic               tag;
        logic [UPPER_W-1:0] upper;
        logic [TRUNC_W-1:0] mant_trunc;
    } cmp_cap_t;

    function automatic logic [CAP_W-1:0] cap_rebuild(
        input cmp_cap_t          c,
        input logic [FILL_W-1:0] fill
    );
        return {c.tag, c.upper, c.mant_trunc, fill};
    endfunction

endpackage

// File: rtl/cap_pipe_stage.sv
// Parameterised-width valid/ready register slice.
// Advances when empty or when downstream accepts; data loads only on a valid advance.
module cap_pipe_stage #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         up_valid,
    output logic         up_ready,
    input  logic [W-1:0] up_data,
    output logic         dn_valid,
    input  logic         dn_ready,
    output logic [W-1:0] dn_data
);

    assign up_ready = !dn_valid | dn_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dn_valid <= 1'b0;
            dn_data  <= '0;
        end else if (up_ready) begin
            dn_valid <= up_valid;
            if (up_valid) dn_data <= up_data;
        end
    end

endmodule

// File: rtl/cap_decompressor129.sv
// Two-stage capability decompressor: re-inserts the 10 dropped mantissa LSBs.
// Define CAP_DECOMP_ROUND_EN to fill with the interval midpoint instead of zero.
import cap_comp_pkg::*;

module cap_decompressor129 #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [CMP_W-1:0] in_cap,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CAP_W-1:0] cap_out,
    output logic [CNT_W-1:0] decomp_cnt
);

`ifdef CAP_DECOMP_ROUND_EN
    localparam logic [FILL_W-1:0] FILL = FILL_MID;
`else
    localparam logic [FILL_W-1:0] FILL = FILL_ZERO;
`endif

    logic             s1_valid;
    logic             s2_ready;
    cmp_cap_t         s1_cap;
    logic [CAP_W-1:0] s1_rebuilt;

    cap_pipe_stage #(.W(CMP_W)) u_s1 (
        .clk      (clk),
        .rst      (rst),
        .up_valid (in_valid),
        .up_ready (in_ready),
        .up_data  (in_cap),
        .dn_valid (s1_valid),
        .dn_ready (s2_ready),
        .dn_data  (s1_cap)
    );

    assign s1_rebuilt = cap_rebuild(s1_cap, FILL);

    cap_pipe_stage #(.W(CAP_W)) u_s2 (
        .clk      (clk),
        .rst      (rst),
        .up_valid (s1_valid),
        .up_ready (s2_ready),
        .up_data  (s1_rebuilt),
        .dn_valid (out_valid),
        .dn_ready (out_ready),
        .dn_data  (cap_out)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            decomp_cnt <= '0;
        end else if (out_valid && out_ready) begin
            decomp_cnt <= decomp_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

endmodule
